// File: rtl/lab3_mem_line_mem_responder_pkg.sv
// Shared types for the 16B line memory responder: message formats, type codes, FSM states
// and the byte-enable helper.
package lab3_mem_line_mem_responder_pkg;

    localparam logic [2:0] MemTypeRead      = 3'd0;
    localparam logic [2:0] MemTypeWrite     = 3'd1;
    localparam logic [2:0] MemTypeWriteInit = 3'd2;

    localparam int unsigned ByteMaskW = 16;

    typedef struct packed {
        logic [2:0]   msg_type;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [2:0]   msg_type;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    function automatic logic is_write(input logic [2:0] msg_type);
        return (msg_type == MemTypeWrite) || (msg_type == MemTypeWriteInit);
    endfunction

    // len==0 means a full line; bytes beyond offset 15 fall off rather than wrapping.
    function automatic logic [ByteMaskW-1:0] gen_wben(input logic [3:0] offset,
                                                      input logic [3:0] len);
        logic [ByteMaskW-1:0] wben;
        logic [4:0]           lim;
        lim = {1'b0, offset} + {1'b0, len};
        for (int i = 0; i < ByteMaskW; i++) begin
            wben[i] = (len == 4'd0) || ((5'(i) >= {1'b0, offset}) && (5'(i) < lim));
        end
        return wben;
    endfunction

endpackage

// File: rtl/lab3_mem_line_mem_array.sv
// Line storage: p_num_lines x 128b, combinational read, synchronous byte-masked write.
module lab3_mem_line_mem_array
    import lab3_mem_line_mem_responder_pkg::*;
#(
    parameter int unsigned p_num_lines = 256,
    parameter int unsigned p_idx_w     = $clog2(p_num_lines)
) (
    input  logic                 clk,
    input  logic [p_idx_w-1:0]   i_idx,
    input  logic [ByteMaskW-1:0] i_wben,
    input  logic [127:0]         i_wdata,
    output logic [127:0]         o_rdata
);

    logic [127:0] r_mem [p_num_lines];

    assign o_rdata = r_mem[i_idx];

    // No reset: contents survive a responder reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < ByteMaskW; b++) begin
            if (i_wben[b]) begin
                r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/lab3_mem_line_mem_responder.sv
// Blocking 16B line memory responder: one request in flight, response after a fixed latency.
module lab3_mem_line_mem_responder
    import lab3_mem_line_mem_responder_pkg::*;
#(
    parameter int unsigned p_num_lines = 256,
    parameter int unsigned p_latency   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  mem_req_16B_t  memreq_msg,
    input  logic          memreq_val,
    output logic          memreq_rdy,
    output mem_resp_16B_t memresp_msg,
    output logic          memresp_val,
    input  logic          memresp_rdy
);

    localparam int unsigned IdxW    = $clog2(p_num_lines);
    localparam logic [3:0]  LatInit = 4'(p_latency);

    state_e        r_state, w_state_next;
    logic [3:0]    r_cnt, w_cnt_next;
    mem_req_16B_t  r_req;
    mem_resp_16B_t r_resp, w_resp_next;
    mem_req_16B_t  w_op;
    logic          w_enter_resp;
    logic          w_op_write;
    logic [ByteMaskW-1:0] w_wben;
    logic [127:0]  w_wdata, w_rdata;
    logic          w_unused_addr;

    // With zero latency RESP is entered on the accept edge, before the request is latched.
    assign w_op       = (r_state == StIdle) ? memreq_msg : r_req;
    assign w_op_write = is_write(w_op.msg_type);
    assign w_wben     = (w_enter_resp && w_op_write) ? gen_wben(w_op.addr[3:0], w_op.len) : '0;
    assign w_wdata    = w_op.data << {w_op.addr[3:0], 3'b000};
    assign w_unused_addr = ^w_op.addr[31:4+IdxW];

    lab3_mem_line_mem_array #(
        .p_num_lines (p_num_lines),
        .p_idx_w     (IdxW)
    ) u_array (
        .clk     (clk),
        .i_idx   (w_op.addr[4 +: IdxW]),
        .i_wben  (w_wben),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        memreq_rdy   = 1'b0;
        memresp_val  = 1'b0;
        w_enter_resp = 1'b0;
        unique case (r_state)
            StIdle: begin
                memreq_rdy = 1'b1;
                if (memreq_val) begin
                    w_cnt_next = LatInit;
                    if (p_latency == 0) begin
                        w_state_next = StResp;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_next = StWait;
                    end
                end
            end
            StWait: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = StResp;
                    w_enter_resp = 1'b1;
                end
            end
            StResp: begin
                memresp_val = 1'b1;
                if (memresp_rdy) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_resp_next          = '0;
        w_resp_next.msg_type = w_op.msg_type;
        w_resp_next.opaque   = w_op.opaque;
        w_resp_next.len      = w_op.len;
        w_resp_next.data     = w_op_write ? 128'd0 : w_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_req   <= '0;
            r_resp  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (memreq_val && memreq_rdy) begin
                r_req <= memreq_msg;
            end
            if (w_enter_resp) begin
                r_resp <= w_resp_next;
            end
        end
    end

    assign memresp_msg = r_resp;

endmodule
